// File: rtl/bram_sdp_param.sv
// Simple-dual-port block RAM with per-byte write enables, read-valid tracking and self-clear after reset.
// Define BRAM_SDP_BYPASS_EN to forward same-cycle write data to a colliding read (default: read-first).
module bram_sdp_param #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 512,
    parameter int AW      = $clog2(DEPTH),
    parameter int OUT_REG = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     data,
    input  logic [AW-1:0]        wraddress,
    input  logic                 wren,
    input  logic [WIDTH/8-1:0]   byteena,
    input  logic [AW-1:0]        rdaddress,
    input  logic                 rden,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic                 busy
);

    localparam int              NB        = WIDTH / 8;
    localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_clrAddr;
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [WIDTH-1:0]     r_s1Data;
    logic                 r_s1Valid;

    logic                 w_clearing;
    logic                 w_run;
    logic                 w_wrInRange;
    logic                 w_rdInRange;
    logic                 w_wrAccept;
    logic                 w_rdAccept;
    logic                 w_memWe;
    logic [AW-1:0]        w_memAddr;
    logic [WIDTH-1:0]     w_memData;
    logic [NB-1:0]        w_memBe;
    logic [WIDTH-1:0]     w_rdWord;

    assign w_clearing  = resetn && (r_state == S_CLEAR);
    assign w_run       = resetn && (r_state == S_RUN);
    assign w_wrInRange = ({1'b0, wraddress} < DEPTH_W);
    assign w_rdInRange = ({1'b0, rdaddress} < DEPTH_W);
    assign w_wrAccept  = w_run && wren && w_wrInRange;
    assign w_rdAccept  = w_run && rden;
    assign busy        = !resetn || (r_state == S_CLEAR);

    // The clear sequence borrows the single write port until every word has been zeroed.
    assign w_memWe   = w_clearing || w_wrAccept;
    assign w_memAddr = w_clearing ? r_clrAddr : wraddress;
    assign w_memData = w_clearing ? '0 : data;
    assign w_memBe   = w_clearing ? '1 : byteena;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_CLEAR;
            r_clrAddr <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clrAddr <= r_clrAddr + 1'b1;
                    if (r_clrAddr == LAST_ADDR) r_state <= S_RUN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_memWe) begin
            for (int i = 0; i < NB; i++) begin
                if (w_memBe[i]) r_mem[w_memAddr][8*i +: 8] <= w_memData[8*i +: 8];
            end
        end
    end

    // Array read sees the pre-write word, so colliding reads are read-first unless forwarded.
    always_comb begin
        w_rdWord = '0;
        if (w_rdInRange) begin
            w_rdWord = r_mem[rdaddress];
`ifdef BRAM_SDP_BYPASS_EN
            if (w_wrAccept && (wraddress == rdaddress)) begin
                for (int i = 0; i < NB; i++) begin
                    if (byteena[i]) w_rdWord[8*i +: 8] = data[8*i +: 8];
                end
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
        end else begin
            r_s1Valid <= w_rdAccept;
            if (w_rdAccept) r_s1Data <= w_rdWord;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_outReg
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    q       <= '0;
                    q_valid <= 1'b0;
                end else begin
                    q_valid <= r_s1Valid;
                    if (r_s1Valid) q <= r_s1Data;
                end
            end
        end else begin : g_noOutReg
            assign q       = r_s1Data;
            assign q_valid = r_s1Valid;
        end
    endgenerate

endmodule
